// File: rtl/lzrw1_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | lzrw1_pkg                                                              |
// | Shared types, constants and copy-item decoder for the LZRW1 datapath.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package lzrw1_pkg;

  localparam int MIN_MATCH   = 3;
  localparam int MAX_MATCH   = 16;
  localparam int OFFSET_BITS = 12;

  typedef struct packed {
    logic [OFFSET_BITS-1:0] offset;
    logic [3:0]             len_m1;
  } copy_item_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LIT  = 2'd1,
    S_COPY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // byte0[7:4] carries offset[11:8], byte0[3:0] carries length-1.
  function automatic copy_item_t decodeCopy(input logic [7:0] byte0,
                                            input logic [7:0] byte1);
    copy_item_t item;
    item.offset = {byte0[7:4], byte1};
    item.len_m1 = byte0[3:0];
    return item;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lzrw1_decompressor_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | lzrw1_decompressor_if                                                  |
// | Compressed-item input stream and plaintext output stream bundle.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface lzrw1_decompressor_if;

  logic       in_valid;
  logic       in_ready;
  logic       in_is_copy;
  logic [7:0] in_byte0;
  logic [7:0] in_byte1;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       done;
  logic       err;

  modport master (
    output in_valid, in_is_copy, in_byte0, in_byte1, in_last, out_ready,
    input  in_ready, out_valid, out_byte, done, err
  );

  modport slave (
    input  in_valid, in_is_copy, in_byte0, in_byte1, in_last, out_ready,
    output in_ready, out_valid, out_byte, done, err
  );

endinterface
`default_nettype wire

// File: rtl/lzrw1_history_ram.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | lzrw1_history_ram                                                      |
// | Circular history: one synchronous write port, one async read port.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module lzrw1_history_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clock,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_wAddr,
  input  wire logic [7:0]    i_wData,
  input  wire logic [AW-1:0] i_rAddr,
  output logic [7:0]         o_rData
);

  // No reset: contents are logically discarded by resetting the write pointer.
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_wAddr] <= i_wData;
    end
  end

  assign o_rData = r_mem[i_rAddr];

endmodule
`default_nettype wire

// File: rtl/lzrw1_decompressor.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | lzrw1_decompressor                                                     |
// | LZRW1 item stream -> plaintext bytes via a circular history buffer.    |
// | Optional: LZRW1_DECOMP_BOUNDS_CHECK_EN enables malformed-copy checks.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module lzrw1_decompressor
  import lzrw1_pkg::*;
#(
  parameter int TABLESIZE = 4096,
  parameter int MAXLEN    = 16
) (
  input  wire logic           clock,
  input  wire logic           reset,
  lzrw1_decompressor_if.slave io
);

  localparam int c_AW = $clog2(TABLESIZE);
  localparam int c_RW = $clog2(MAXLEN) + 1;

  generate
    if (((TABLESIZE & (TABLESIZE - 1)) != 0) || (TABLESIZE > 4096)) begin : g_paramCheck
      $error("TABLESIZE must be a power of two no larger than 4096");
    end
  endgenerate

  state_t                 r_state;
  state_t                 w_nextState;
  logic [c_AW-1:0]        r_wptr;
  logic [OFFSET_BITS-1:0] r_off;
  logic [c_RW-1:0]        r_rem;
  logic [7:0]             r_lit;
  logic                   r_last;
  logic                   r_live;

  copy_item_t             w_item;
  logic                   w_accept;
  logic                   w_fire;
  logic [c_AW-1:0]        w_rdAddr;
  logic [7:0]             w_histByte;
  logic [7:0]             w_outByte;

  assign w_item   = decodeCopy(io.in_byte0, io.in_byte1);
  assign w_accept = io.in_valid && r_live && (r_state == S_IDLE);
  assign w_fire   = io.out_ready && ((r_state == S_LIT) || (r_state == S_COPY));
  // Offset distance is taken modulo the table depth by truncation.
  assign w_rdAddr = r_wptr - r_off[c_AW-1:0];

  lzrw1_history_ram #(
    .DEPTH (TABLESIZE),
    .AW    (c_AW)
  ) u_hist (
    .clock   (clock),
    .i_we    (w_fire),
    .i_wAddr (r_wptr),
    .i_wData (io.out_byte),
    .i_rAddr (w_rdAddr),
    .o_rData (w_histByte)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_off   <= '0;
      r_rem   <= '0;
      r_lit   <= '0;
      r_last  <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_last <= io.in_last;
        r_lit  <= io.in_byte0;
        r_off  <= w_item.offset;
        r_rem  <= c_RW'(w_item.len_m1) + c_RW'(1);
      end
      // Each emitted byte is written back before the next read, which is
      // what makes overlapping copies expand into runs.
      if (w_fire) begin
        r_wptr <= r_wptr + 1'b1;
        if (r_state == S_COPY) begin
          r_rem <= r_rem - 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_nextState  = r_state;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.done      = 1'b0;
    w_outByte    = 8'h00;
    case (r_state)
      S_IDLE: begin
        io.in_ready = r_live;
        if (w_accept) begin
          w_nextState = io.in_is_copy ? S_COPY : S_LIT;
        end
      end
      S_LIT: begin
        io.out_valid = 1'b1;
        w_outByte    = r_lit;
        if (io.out_ready) begin
          w_nextState = r_last ? S_DONE : S_IDLE;
        end
      end
      S_COPY: begin
        io.out_valid = 1'b1;
        w_outByte    = w_histByte;
        if (io.out_ready && (r_rem == c_RW'(1))) begin
          w_nextState = r_last ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        io.done = 1'b1;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

`ifdef LZRW1_DECOMP_BOUNDS_CHECK_EN
  localparam int          c_CW   = OFFSET_BITS + 1;
  localparam logic [c_AW:0] c_FULL = TABLESIZE[c_AW:0];

  logic [c_AW:0] r_produced;
  logic          r_bad;
  logic          r_err;
  logic          w_bad;

  assign w_bad = io.in_is_copy &&
                 ((w_item.offset == '0) ||
                  ({1'b0, w_item.offset} > c_CW'(r_produced)) ||
                  (w_item.len_m1 < 4'(MIN_MATCH - 1)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_produced <= '0;
      r_bad      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_bad <= w_bad;
        if (w_bad) begin
          r_err <= 1'b1;
        end
      end
      if (w_fire && (r_produced != c_FULL)) begin
        r_produced <= r_produced + 1'b1;
      end
    end
  end

  assign io.out_byte = r_bad ? 8'h00 : w_outByte;
  assign io.err      = r_err;
`else
  assign io.out_byte = w_outByte;
  assign io.err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lzrw1_decompressor.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_lzrw1_decompressor                                                  |
// | Directed + randomized streams checked against a plaintext-queue model. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_lzrw1_decompressor;

  typedef struct packed {
    logic       isCopy;
    logic [7:0] b0;
    logic [7:0] b1;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  item_t      items[$];
  logic [7:0] expq[$];
  logic [7:0] got[$];
  int         gotCyc[$];
  int         acceptCyc[$];

  lzrw1_decompressor_if io();

  lzrw1_decompressor #(
    .TABLESIZE (4096),
    .MAXLEN    (16)
  ) dut (
    .clock (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic newStream();
    items.delete();
    expq.delete();
  endtask

  // Reference model: plaintext grows by the literal, or by len bytes each
  // copied from `off` positions back in the plaintext produced so far.
  task automatic addLit(input logic [7:0] b);
    items.push_back('{isCopy: 1'b0, b0: b, b1: 8'h00});
    expq.push_back(b);
  endtask

  task automatic addCopy(input logic [7:0] b0, input logic [7:0] b1);
    int off;
    int len;
    items.push_back('{isCopy: 1'b1, b0: b0, b1: b1});
    off = {b0[7:4], b1};
    len = b0[3:0] + 1;
    for (int k = 0; k < len; k++) expq.push_back(expq[expq.size() - off]);
  endtask

  task automatic genRandom(input int nItems, input int copyPct, input int lenLo);
    int off;
    int maxOff;
    int lenF;
    for (int n = 0; n < nItems; n++) begin
      if (expq.size() == 0 || $urandom_range(99, 0) >= copyPct) begin
        addLit(8'($urandom_range(255, 0)));
      end else begin
        maxOff = (expq.size() > 4095) ? 4095 : expq.size();
        if ($urandom_range(1, 0) == 0 && maxOff > 20) maxOff = 20;
        off  = $urandom_range(maxOff, 1);
        lenF = $urandom_range(15, lenLo);
        addCopy({4'(off >> 8), 4'(lenF)}, 8'(off));
      end
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Drives items and collects output; returns early when abortAt bytes have
  // been taken and another is on offer.
  task automatic runStream(input int stallPct, input int abortAt, input int budget);
    int   idx = 0;
    int   cyc = 0;
    logic prevStall = 1'b0;
    logic [7:0] prevByte = 8'h00;
    got.delete();
    gotCyc.delete();
    acceptCyc.delete();
    while (1) begin
      @(negedge clk);
      if (idx < items.size()) begin
        io.in_valid   = 1'b1;
        io.in_is_copy = items[idx].isCopy;
        io.in_byte0   = items[idx].b0;
        io.in_byte1   = items[idx].b1;
        io.in_last    = (idx == items.size() - 1);
      end else begin
        io.in_valid = 1'b0;
      end
      io.out_ready = ($urandom_range(99, 0) >= stallPct);
      #1;
      if (prevStall) begin
        chk("stall_valid", 32'(io.out_valid), 32'd1);
        chk("stall_byte", 32'(io.out_byte), 32'(prevByte));
      end
      if (abortAt >= 0 && got.size() == abortAt && io.out_valid) return;
      if (io.in_valid && io.in_ready) begin
        acceptCyc.push_back(cyc);
        idx++;
      end
      if (io.out_valid && io.out_ready) begin
        got.push_back(io.out_byte);
        gotCyc.push_back(cyc);
      end
      prevStall = io.out_valid && !io.out_ready;
      prevByte  = io.out_byte;
      if (io.done) break;
      cyc++;
      if (cyc > budget) break;
    end
    io.in_valid = 1'b0;
    chk("done", 32'(io.done), 32'd1);
  endtask

  task automatic compareStream(input string name);
    int n;
    chk({name, "_len"}, 32'(got.size()), 32'(expq.size()));
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(expq[i]));
  endtask

  initial begin
    reset = 1'b1;
    io.in_valid = 1'b0; io.in_is_copy = 1'b0; io.in_byte0 = 8'h00;
    io.in_byte1 = 8'h00; io.in_last = 1'b0; io.out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(io.in_ready), 32'd0);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_out_byte", 32'(io.out_byte), 32'd0);
    chk("rst_done", 32'(io.done), 32'd0);
    chk("rst_err", 32'(io.err), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", 32'(io.in_ready), 32'd1);

    // "abc": one byte every two cycles, first one cycle after accept.
    newStream();
    addLit(8'h61); addLit(8'h62); addLit(8'h63);
    runStream(0, -1, 100);
    compareStream("abc");
    if (gotCyc.size() == 3 && acceptCyc.size() >= 1) begin
      chk("abc_lat0", 32'(gotCyc[0] - acceptCyc[0]), 32'd1);
      chk("abc_gap1", 32'(gotCyc[1] - gotCyc[0]), 32'd2);
      chk("abc_gap2", 32'(gotCyc[2] - gotCyc[1]), 32'd2);
    end
    chk("abc_in_ready_done", 32'(io.in_ready), 32'd0);
    chk("abc_out_valid_done", 32'(io.out_valid), 32'd0);

    // "ab" + copy off=2 len=6 -> "abababab".
    doReset();
    newStream();
    addLit(8'h61); addLit(8'h62); addCopy(8'h05, 8'h02);
    runStream(0, -1, 100);
    compareStream("abab");
    chk("abab_len_const", 32'(got.size()), 32'd8);

    // Overlap run: 'x' + copy off=1 len=16 -> 17 x 0x78.
    doReset();
    newStream();
    addLit(8'h78); addCopy(8'h0F, 8'h01);
    runStream(0, -1, 100);
    compareStream("run");
    for (int i = 0; i < got.size(); i++) chk($sformatf("run_x[%0d]", i), 32'(got[i]), 32'h78);

    // Stalled 10-byte copy against stall-free reference.
    doReset();
    newStream();
    addLit(8'h6B); addLit(8'h6C); addLit(8'h6D); addCopy(8'h09, 8'h03);
    runStream(45, -1, 400);
    compareStream("stall");

    // Reset during the 5th byte of a 16-byte copy, then "hi".
    doReset();
    newStream();
    addLit(8'h71); addCopy(8'h0F, 8'h01);
    runStream(0, 5, 200);
    chk("abort_taken", 32'(got.size()), 32'd5);
    reset = 1'b0;
    #1;
    chk("abort_out_valid", 32'(io.out_valid), 32'd0);
    chk("abort_in_ready", 32'(io.in_ready), 32'd0);
    chk("abort_out_byte", 32'(io.out_byte), 32'd0);
    doReset();
    newStream();
    addLit(8'h68); addLit(8'h69);
    runStream(0, -1, 100);
    compareStream("hi");

    // Copy referencing data that was never produced.
    doReset();
    newStream();
    items.push_back('{isCopy: 1'b1, b0: 8'h02, b1: 8'h05});
    runStream(0, -1, 100);
    chk("bad_len", 32'(got.size()), 32'd3);
`ifdef LZRW1_DECOMP_BOUNDS_CHECK_EN
    chk("bad_err", 32'(io.err), 32'd1);
    for (int i = 0; i < got.size(); i++) chk($sformatf("bad_zero[%0d]", i), 32'(got[i]), 32'h00);
    repeat (3) @(negedge clk);
    chk("bad_err_sticky", 32'(io.err), 32'd1);
`else
    chk("bad_err_off", 32'(io.err), 32'd0);
`endif
    doReset();
    chk("err_after_reset", 32'(io.err), 32'd0);

    // Random streams with stalls.
    for (int s = 0; s < 3; s++) begin
      doReset();
      newStream();
      genRandom($urandom_range(40, 20), 50, 2);
      runStream(30, -1, 3000);
      compareStream($sformatf("rnd%0d", s));
    end

    // Long stream crossing the write-pointer wrap.
    doReset();
    newStream();
    genRandom(420, 90, 8);
    runStream(0, -1, 20000);
    compareStream("wrap");
    chk("wrap_big", 32'(expq.size() > 4096), 32'(got.size() > 4096));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lzrw1_decompressor.md
Name: lzrw1_decompressor

Overview:
- LZRW1 decompressor: the inverse of compressor_top.
- Accepts one compressed item per handshake (a literal byte, or a 2-byte copy item) with the item's control-word bit attached.
- Replays bytes from a circular history buffer and emits reconstructed plaintext one byte per output handshake.
- Sits between the compressed-stream source (compArray/controlWord unpacker) and the plaintext consumer.

Parameters:
- TABLESIZE, 4096: history depth in bytes; must be a power of 2, at most 4096 (12-bit offset).
- MAXLEN, 16: maximum copy length in bytes; fixed by the 4-bit length field.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; reset==0 clears all state.
- in_valid  in  1  compressed item present.
- in_ready  out  1  decompressor can take an item.
- in_is_copy  in  1  control-word bit for the item: 0 = literal, 1 = copy.
- in_byte0  in  8  literal: the byte. Copy: [7:4] = offset[11:8], [3:0] = length-1.
- in_byte1  in  8  copy: offset[7:0]; ignored for literals.
- in_last  in  1  item is the final item of the stream.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  consumer accepts out_byte.
- out_byte  out  8  reconstructed byte.
- done  out  1  final byte of the last item has been accepted.
- err  out  1  sticky malformed-stream flag.

Behaviour:
- Reset values: in_ready=0 during reset, 1 from the first cycle after release. out_valid=0, out_byte=0, done=0, err=0. Write pointer wptr=0, produced count=0, state=IDLE.
- FSM states: IDLE, LIT, COPY, DONE.
- IDLE:
  - in_ready=1.
  - Item accepted on in_valid&&in_ready.
  - Literal: latch byte, go to LIT.
  - Copy: latch off={byte0[7:4],byte1}, rem=byte0[3:0]+1, go to COPY.
  - Latch in_last with the item.
- LIT:
  - out_valid=1, out_byte=latched literal.
  - On out_ready: write the byte to hist[wptr], wptr++ (mod TABLESIZE), produced++ (saturating at TABLESIZE).
  - Next state: DONE if last, else IDLE.
- COPY:
  - out_valid=1, out_byte=hist[(wptr-off) mod TABLESIZE] (combinational read).
  - On out_ready: write that byte to hist[wptr], wptr++, produced++, rem--.
  - When rem reaches 0, go to DONE if last, else IDLE.
  - Overlapping copies (off < length) reproduce run-length patterns, because each copied byte is written before the next read.
- DONE: done=1, in_ready=0, out_valid=0. Held until reset.
- Latency and throughput:
  - Item accepted in cycle N → first out_valid in cycle N+1.
  - Literal costs at least 2 cycles.
  - Copy of length L costs at least L+1 cycles.
- out_byte and out_valid stay stable while out_valid && !out_ready.
- in_ready=0 in LIT/COPY/DONE; input stalls never drop an item.
- Legal copy length field: byte0[3:0] in 2..15 (length 3..16). Field values 0/1 are still executed as lengths 1/2.
- Offset 0: read hist[wptr], i.e. the oldest/stale entry; output is whatever is stored.
- wptr wraps at TABLESIZE-1→0 with no gap.
- Reset asserted mid-copy: output drops immediately, remaining bytes discarded, history contents don't-care (logically empty, produced=0).
- Simultaneous in_valid and DONE: item ignored.

Optional Feature:
- Macro: LZRW1_DECOMP_BOUNDS_CHECK_EN.
- Defined:
  - On accept, a copy with off==0, or off>produced, or length field<2 sets err.
  - The item is still executed, but out_byte is forced to 0x00 for each of its bytes.
  - err is cleared only by reset.
- Undefined: err tied 0 and no checking logic is built.

Decomposition:
- lzrw1_pkg holds:
  - typedef copy_item_t {offset[11:0], len_m1[3:0]}.
  - state enum.
  - constants MIN_MATCH=3, MAX_MATCH=16, OFFSET_BITS=12.
  - function decoding byte0/byte1 into copy_item_t.
- Sub-module lzrw1_history_ram: TABLESIZE×8, one write port, one asynchronous read port.

Test Plan:
- Literals "abc" (3 items, last on 'c'), out_ready=1 → out bytes 0x61,0x62,0x63 at cycles N+1,N+3,N+5; done rises after 'c'.
- Literals 'a','b', then copy byte0=0x05, byte1=0x02 (off=2, len=6) → "ab" then "ababab", 8 bytes total.
- Overlap run: literal 'x', then copy off=1 len=16 (byte0=0x0F, byte1=0x01) → 17×0x78.
- Random out_ready deassertion during a 10-byte copy → out_byte held stable while stalled, no byte lost or duplicated, output identical to the stall-free run.
- Reset pulled low during the 5th byte of a 16-byte copy, then stream "hi" → out_valid low within reset, next outputs 0x68,0x69, done=1.
- With LZRW1_DECOMP_BOUNDS_CHECK_EN: first item copy off=5 → err=1, 0x00 bytes emitted; err stays 1 until reset.
